// File: rtl/prewish5k_input_conditioner_if.sv
// Raw pad levels in, conditioned levels and strobes out, for prewish5k_input_conditioner.
interface prewish5k_input_conditioner_if #(
  parameter int N_CH = 9
);
  logic [N_CH-1:0] i_raw;
  logic [N_CH-1:0] o_level;
  logic [N_CH-1:0] o_rise;
  logic [N_CH-1:0] o_fall;
  logic [N_CH-1:0] o_held;
  logic            o_any_edge;
  logic            o_tick;

  modport master (
    output i_raw,
    input  o_level, o_rise, o_fall, o_held, o_any_edge, o_tick
  );

  modport slave (
    input  i_raw,
    output o_level, o_rise, o_fall, o_held, o_any_edge, o_tick
  );
endinterface

// File: rtl/prewish5k_input_conditioner.sv
// Synchronise, polarity-correct and debounce N pad inputs; level, edge, long-press strobes.
// Latency: SYNC_STAGES clocks plus DEBOUNCE_COUNT debounce ticks to accept a new level.
// No backpressure: strobes are single-cycle and must be consumed when they fire.
module prewish5k_input_conditioner #(
  parameter int              N_CH           = 9,
  parameter logic [N_CH-1:0] ACTIVE_LOW     = {N_CH{1'b1}},
  parameter int              SYNC_STAGES    = 2,
  parameter int              TICK_DIV_BITS  = 16,
  parameter int              DEBOUNCE_COUNT = 16,
  parameter int              HOLD_COUNT     = 0
) (
  input logic                           i_clk,
  input logic                           i_rst,
  prewish5k_input_conditioner_if.slave  io
);

  localparam int CNT_W  = $clog2(DEBOUNCE_COUNT) + 1;
  localparam int HOLD_W = (HOLD_COUNT > 0) ? $clog2(HOLD_COUNT + 1) : 1;

  logic            tick;
  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [N_CH-1:0] accept;

  generate
    if (TICK_DIV_BITS == 0) begin : g_no_div
      logic tick_q;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) tick_q <= 1'b0;
        else       tick_q <= 1'b1;
      end
      assign tick = tick_q;
    end else begin : g_div
      logic [TICK_DIV_BITS-1:0] presc;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) presc <= '0;
        else       presc <= presc + TICK_DIV_BITS'(1);
      end
      assign tick = &presc;
    end
  endgenerate

  assign io.o_tick = tick;

  // Reset loads the inactive pad level so nothing appears to change at reset release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= ACTIVE_LOW;
    end else begin
      sync_q[0] <= io.i_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  generate
    for (genvar n = 0; n < N_CH; n++) begin : g_ch
      logic [CNT_W-1:0] cnt;
      logic             lvl;
      logic             rise_q;
      logic             fall_q;

      assign accept[n] = (s[n] != lvl) && tick && (cnt == CNT_W'(DEBOUNCE_COUNT - 1));

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          cnt    <= '0;
          lvl    <= 1'b0;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          rise_q <= accept[n] && s[n];
          fall_q <= accept[n] && !s[n];
          if ((s[n] == lvl) || accept[n]) cnt <= '0;
          else if (tick)                  cnt <= cnt + CNT_W'(1);
          if (accept[n]) lvl <= s[n];
        end
      end

      assign io.o_level[n] = lvl;
      assign io.o_rise[n]  = rise_q;
      assign io.o_fall[n]  = fall_q;

      if (HOLD_COUNT > 0) begin : g_hold
        logic [HOLD_W-1:0] hcnt;
        logic              held_q;

        // Counter saturates at HOLD_COUNT so a long press pulses exactly once.
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            hcnt   <= '0;
            held_q <= 1'b0;
          end else begin
            held_q <= 1'b0;
            if (!lvl) begin
              hcnt <= '0;
            end else if (tick && (hcnt < HOLD_W'(HOLD_COUNT))) begin
              hcnt   <= hcnt + HOLD_W'(1);
              held_q <= (hcnt == HOLD_W'(HOLD_COUNT - 1));
            end
          end
        end
        assign io.o_held[n] = held_q;
      end else begin : g_no_hold
        assign io.o_held[n] = 1'b0;
      end
    end
  endgenerate

  // Registered from the same accept terms as the strobes, so it lands in their cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) io.o_any_edge <= 1'b0;
    else       io.o_any_edge <= |accept;
  end

endmodule

// File: tb/tb_prewish5k_input_conditioner.sv
// Directed and random checks of prewish5k_input_conditioner against a per-cycle reference model.
module tb_prewish5k_input_conditioner;

  localparam int            N  = 9;
  localparam logic [N-1:0]  AL = 9'h1FF;
  localparam int            SS = 2;
  localparam int            DC = 4;
  localparam int            HC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] raw = 9'h1FF;

  always #5 clk = ~clk;

  prewish5k_input_conditioner_if #(.N_CH(N)) bus0 ();
  prewish5k_input_conditioner_if #(.N_CH(N)) bus1 ();
  assign bus0.i_raw = raw;
  assign bus1.i_raw = raw;

  prewish5k_input_conditioner #(
    .N_CH(N), .ACTIVE_LOW(AL), .SYNC_STAGES(SS), .TICK_DIV_BITS(0),
    .DEBOUNCE_COUNT(DC), .HOLD_COUNT(HC)
  ) dut0 (.i_clk(clk), .i_rst(rst), .io(bus0));

  prewish5k_input_conditioner #(
    .N_CH(N), .ACTIVE_LOW(AL), .SYNC_STAGES(SS), .TICK_DIV_BITS(3),
    .DEBOUNCE_COUNT(DC), .HOLD_COUNT(HC)
  ) dut1 (.i_clk(clk), .i_rst(rst), .io(bus1));

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: raw history queue plus, per DUT and channel, how many
  // consecutive ticks the clean input has disagreed with the output level
  // and how many ticks the output has been continuously active.
  logic [N-1:0] hist[$];
  int           edges;
  logic [N-1:0] m_level [2];
  logic [N-1:0] m_rise  [2];
  logic [N-1:0] m_fall  [2];
  logic [N-1:0] m_held  [2];
  logic         m_any   [2];
  int           streak  [2][N];
  int           hold    [2][N];

  function automatic logic tick_exp(int d, int e);
    if (d == 0) return (e >= 1);
    return ((e % 8) == 7);
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SS; i++) hist.push_back(AL);
    edges = 0;
    for (int d = 0; d < 2; d++) begin
      m_level[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_held[d] = '0; m_any[d] = 1'b0;
      for (int ch = 0; ch < N; ch++) begin
        streak[d][ch] = 0;
        hold[d][ch]   = 0;
      end
    end
  endfunction

  function automatic void model_edge();
    logic [N-1:0] sv;
    logic         tk;
    logic         lv;
    sv = hist[0] ^ AL;
    for (int d = 0; d < 2; d++) begin
      tk = tick_exp(d, edges);
      m_rise[d] = '0; m_fall[d] = '0; m_held[d] = '0;
      for (int ch = 0; ch < N; ch++) begin
        lv = m_level[d][ch];
        if (sv[ch] == lv) begin
          streak[d][ch] = 0;
        end else if (tk) begin
          streak[d][ch] = streak[d][ch] + 1;
          if (streak[d][ch] == DC) begin
            streak[d][ch]   = 0;
            m_level[d][ch]  = sv[ch];
            m_rise[d][ch]   = sv[ch];
            m_fall[d][ch]   = !sv[ch];
          end
        end
        if (!lv) begin
          hold[d][ch] = 0;
        end else if (tk && hold[d][ch] < HC) begin
          hold[d][ch] = hold[d][ch] + 1;
          if (hold[d][ch] == HC) m_held[d][ch] = 1'b1;
        end
      end
      m_any[d] = |(m_rise[d] | m_fall[d]);
    end
    void'(hist.pop_front());
    hist.push_back(raw);
    edges = edges + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic compare();
    chk("d0_level", 32'(bus0.o_level),    32'(m_level[0]));
    chk("d0_rise",  32'(bus0.o_rise),     32'(m_rise[0]));
    chk("d0_fall",  32'(bus0.o_fall),     32'(m_fall[0]));
    chk("d0_held",  32'(bus0.o_held),     32'(m_held[0]));
    chk("d0_any",   32'(bus0.o_any_edge), 32'(m_any[0]));
    chk("d0_tick",  32'(bus0.o_tick),     32'(tick_exp(0, edges)));
    chk("d1_level", 32'(bus1.o_level),    32'(m_level[1]));
    chk("d1_rise",  32'(bus1.o_rise),     32'(m_rise[1]));
    chk("d1_fall",  32'(bus1.o_fall),     32'(m_fall[1]));
    chk("d1_held",  32'(bus1.o_held),     32'(m_held[1]));
    chk("d1_any",   32'(bus1.o_any_edge), 32'(m_any[1]));
    chk("d1_tick",  32'(bus1.o_tick),     32'(tick_exp(1, edges)));
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_lvl0"},  32'(bus0.o_level), 32'd0);
    chk({tag, "_stb0"},  32'(bus0.o_rise | bus0.o_fall | bus0.o_held), 32'd0);
    chk({tag, "_misc0"}, 32'({bus0.o_any_edge, bus0.o_tick}), 32'd0);
    chk({tag, "_lvl1"},  32'(bus1.o_level), 32'd0);
    chk({tag, "_stb1"},  32'(bus1.o_rise | bus1.o_fall | bus1.o_held), 32'd0);
    chk({tag, "_misc1"}, 32'({bus1.o_any_edge, bus1.o_tick}), 32'd0);
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #2;
    check_all_zero(tag);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int first_rise;
    int tick_cnt;

    model_reset();
    #1 rst = 1'b1;
    #1 check_all_zero("por");
    repeat (3) step();
    rst = 1'b0;

    // Idle inputs after reset release: no level, no strobes, tick every cycle.
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t1_level",  32'(bus0.o_level), 32'd0);
      chk("t1_strobe", 32'(bus0.o_rise | bus0.o_fall | bus0.o_held | N'(bus0.o_any_edge)), 32'd0);
      chk("t1_tick",   32'(bus0.o_tick), 32'd1);
    end

    // Button press accepted on the 6th edge, with any_edge in the same cycle.
    raw[0] = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("t2_level0", 32'(bus0.o_level[0]), 32'(e == 6));
      chk("t2_rise0",  32'(bus0.o_rise[0]),  32'(e == 6));
      chk("t2_any",    32'(bus0.o_any_edge), 32'(e == 6));
    end

    // Long press: one held pulse 8 ticks after the rise, then silence.
    for (int k = 1; k <= 28; k++) begin
      step();
      chk("t4_held0", 32'(bus0.o_held[0]), 32'(k == 8));
      chk("t4_rise0", 32'(bus0.o_rise[0]), 32'd0);
    end
    raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t4_fall0", 32'(bus0.o_fall[0]), 32'(k == 6));
    end

    // Short press: released one cycle after the rise, falls before the hold limit.
    raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t4_rerise0", 32'(bus0.o_rise[0]), 32'(k == 6));
    end
    step();
    raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t4_sfall0", 32'(bus0.o_fall[0]), 32'(k == 6));
      chk("t4_noheld", 32'(bus0.o_held[0]), 32'd0);
    end

    // Three-cycle glitch on DIP bit 2 is rejected; a sustained change is accepted.
    raw[3] = 1'b0;
    repeat (3) step();
    raw[3] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t3_glitch_lvl", 32'(bus0.o_level[3]), 32'd0);
      chk("t3_glitch_stb", 32'(bus0.o_rise[3] | bus0.o_fall[3]), 32'd0);
    end
    raw[3] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t3_rise3", 32'(bus0.o_rise[3]), 32'(k == 6));
    end
    raw[3] = 1'b1;
    repeat (8) step();

    // Random multi-channel activity against the model on both DUTs.
    for (int seg = 0; seg < 90; seg++) begin
      raw = raw ^ (N'($urandom) & N'($urandom) & N'($urandom));
      repeat ($urandom_range(1, 12)) step();
    end

    // Reset with channels active and one mid-debounce; all re-qualify from scratch.
    raw = 9'h1F0;
    repeat (10) step();
    raw[5] = 1'b0;
    repeat (3) step();
    chk("t6_pre_level", 32'(bus0.o_level), 32'h00F);
    pulse_reset("t6_rst");
    for (int e = 1; e <= 6; e++) begin
      step();
      chk("t6_relevel", 32'(bus0.o_level), (e == 6) ? 32'h02F : 32'd0);
      chk("t6_rerise",  32'(bus0.o_rise),  (e == 6) ? 32'h02F : 32'd0);
    end

    // Prescaled DUT: tick every 8 clocks, DIP bit 0 accepted on the 4th tick.
    raw = 9'h1FF;
    pulse_reset("t5_rst");
    raw[1] = 1'b0;
    first_rise = -1;
    tick_cnt   = 0;
    for (int e = 1; e <= 64; e++) begin
      step();
      if (bus1.o_tick) tick_cnt++;
      if (first_rise < 0 && bus1.o_level[1]) first_rise = e;
    end
    chk("t5_tick_count",  32'(tick_cnt), 32'd8);
    chk("t5_rise_window", 32'(first_rise >= 27 && first_rise <= 34), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
